seq_right_shifter: RTL and testbench
====================================

Name: seq_right_shifter

Overview:
- Multi-cycle 16-bit right shifter/rotator for the WISC ALU datapath.
- Complements the combinational left shifter: handles SRA, SRL and ROR by resolving one shift-amount bit per clock (stage weights 8, 4, 2, 1).
- Uses a ready/start/done handshake toward the execute-stage controller.
- Registered result and zero flag are held until the next accepted operation.

Parameters:
- WIDTH, 16: data width in bits.
- SHW, 4: shift-amount width; WIDTH must equal 2**SHW. Also the number of BUSY cycles.

Ports:
- clk  input  1: rising-edge clock.
- rst_n  input  1: asynchronous active-low reset.
- start  input  1: request; accepted only when ready=1.
- a  input  WIDTH: operand, captured on accept.
- shift  input  SHW: shift amount, captured on accept.
- mode  input  2: operation select. 00 SRL, 01 SRA, 10 ROR, 11 SRL (alias).
- ready  output  1: block can accept start this cycle.
- busy  output  1: operation in progress.
- done  output  1: one-cycle pulse; result valid.
- out  output  WIDTH: result register.
- zero  output  1: registered (out == 0), updated with out.

Behaviour:
- Reset (async assert, any state): state=IDLE, out=0, zero=1, done=0, busy=0, ready=1. Internal working regs cleared.
- Reset mid-operation aborts the operation; no done is produced.
- States: IDLE, BUSY, DONE.
  - ready=1 in IDLE and DONE.
  - busy=1 only in BUSY.
  - done=1 only in DONE.
- Accept edge (start=1 and ready=1):
  - Capture a into the working reg; capture shift and mode.
  - Stage counter k = SHW-1.
  - Go to BUSY.
  - out and zero keep their old values until completion.
- BUSY, each edge:
  - If shift[k]=1, apply a shift of 2**k to the working reg:
    - SRL: zero-fill from the MSB.
    - SRA: fill with the captured a[WIDTH-1]. The sign is taken from the original operand, not re-read per stage.
    - ROR: bits shifted out of the LSB enter at the MSB.
  - If shift[k]=0, the working reg is unchanged.
  - When k=0: load out with the final value, load zero, go to DONE.
  - Otherwise k decrements.
- Latency: start accepted at edge T -> out valid and done=1 in the cycle after edge T+SHW (4 BUSY cycles for default).
- DONE lasts exactly one cycle.
  - start=1 in DONE is accepted (back-to-back): next state BUSY, done still pulses this cycle.
  - Otherwise next state is IDLE.
- start in BUSY is ignored; captured operands are unaffected by input changes after accept.
- out holds its value through IDLE and through a subsequent BUSY until the next completion.
- shift=0: result equals a in all modes. Full SHW-cycle latency applies unless the optional feature is enabled.
- shift=WIDTH-1 boundaries:
  - SRA of a negative value yields all ones except where fill is defined (0x8000 >> 15 = 0xFFFF).
  - SRL yields a[15] in bit 0.
  - ROR by 15 equals a rotate left by 1.
- Reserved mode 11 behaves identically to 00; no error output.

Optional Feature:
- Macro SHR_EARLY_DONE_EN.
- When defined: at each BUSY edge, if the captured shift bits below the current k are all zero, the current stage is applied, out/zero are loaded, and the state goes to DONE immediately.
  - Latency becomes (SHW - index of lowest set shift bit) cycles.
  - shift=0 completes after 1 BUSY cycle.
  - shift=8 completes after 1 BUSY cycle.
  - shift=1 still takes SHW cycles.
- When undefined: fixed SHW-cycle latency for every operation.
- Results are identical in both builds.

Test Plan:
- SRA a=0x8000, shift=4 -> out=0xF800, zero=0, done pulses exactly 4 cycles after accept edge, busy high for those 4 cycles.
- ROR a=0x1234, shift=4 -> 0x4123. Then SRL a=0x8000, shift=15 -> 0x0001. Then SRA a=0x8000, shift=15 -> 0xFFFF.
- SRL a=0x00F0, shift=8 -> out=0x0000, zero=1. Without the macro, latency is 4 cycles. With SHR_EARLY_DONE_EN, latency is 1 cycle; shift=0 also takes 1 cycle and returns a unchanged.
- Back-to-back: start held in DONE with SRA a=0x7FFF, shift=1 -> accepted, second done 4 cycles later, out=0x3FFF. Change a and mode while BUSY -> result unaffected. Extra start pulses in BUSY ignored.
- Assert rst_n=0 during the 2nd BUSY cycle -> immediately out=0, zero=1, ready=1, busy=0, no done pulse. After release, a new ROR a=0x0001, shift=1 -> 0x8000.

Source files
------------

// File: rtl/seq_right_shifter.sv
// seq_right_shifter
//   Multi-cycle right shifter/rotator for the WISC ALU datapath. It resolves
//   one shift-amount bit per clock, MSB first, so the stage weights are
//   2**(SHW-1) down to 1. It supports logical right shift, arithmetic right
//   shift and rotate right.
//
// Parameters
//   WIDTH : data width (must equal 2**SHW)
//   SHW   : shift-amount width; also the number of BUSY cycles
//
// Ports
//   clk   in  : rising-edge clock
//   rst_n in  : asynchronous active-low reset
//   start in  : request, accepted only while ready=1
//   a     in  : operand, captured on accept
//   shift in  : shift amount, captured on accept
//   mode  in  : 00 SRL, 01 SRA, 10 ROR, 11 SRL (alias)
//   ready out : block can accept start this cycle (IDLE or DONE)
//   busy  out : operation in progress
//   done  out : one-cycle pulse, out/zero hold the new result
//   out   out : result register, held until the next completion
//   zero  out : registered (out == 0), updated together with out
//
// Build option
//   SHR_EARLY_DONE_EN : when defined, the block finishes as soon as the
//   remaining lower shift bits are all zero. Results are the same in both
//   builds; only the latency changes.

module seq_right_shifter #(
  parameter int WIDTH = 16,
  parameter int SHW   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [SHW-1:0]   shift,
  input  logic [1:0]       mode,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             zero
);

  localparam int KW = (SHW > 1) ? $clog2(SHW) : 1;
  localparam logic [KW-1:0] K_FIRST = KW'(SHW - 1);
  localparam logic [KW-1:0] K_ONE   = KW'(1);

  if (WIDTH != (1 << SHW)) begin : g_bad_cfg
    $error("seq_right_shifter: WIDTH must equal 2**SHW");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  // Mode is decoded once at accept, so the reserved encoding never reaches
  // the datapath.
  typedef enum logic [1:0] {
    OP_SRL,
    OP_SRA,
    OP_ROR
  } op_t;

  state_t           state_q, state_d;
  op_t              op_q, op_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [SHW-1:0]   shift_q, shift_d;
  logic             sign_q, sign_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             zero_q, zero_d;

  logic [WIDTH-1:0] stage_val;
  logic             low_bits_set;
  logic             last_stage;

  function automatic op_t decode_mode(input logic [1:0] m);
    op_t r;
    case (m)
      2'b01:   r = OP_SRA;
      2'b10:   r = OP_ROR;
      default: r = OP_SRL;
    endcase
    return r;
  endfunction

  // Shift by 2**k for a single stage. The SRA fill uses the sign captured at
  // accept time rather than the current working MSB.
  function automatic logic [WIDTH-1:0] shift_stage(
    input logic [WIDTH-1:0] v,
    input op_t              op,
    input logic             sign,
    input logic [KW-1:0]    k
  );
    logic [WIDTH-1:0] ones;
    logic [WIDTH-1:0] shr;
    logic [WIDTH-1:0] fill;
    logic [WIDTH-1:0] wrap;
    logic [WIDTH-1:0] r;
    int unsigned      amt;
    ones = '1;
    amt  = 32'd1 << k;
    shr  = v >> amt;
    fill = ~(ones >> amt);
    wrap = v << (WIDTH - amt);
    case (op)
      OP_SRA:  r = sign ? (shr | fill) : shr;
      OP_ROR:  r = shr | wrap;
      default: r = shr;
    endcase
    return r;
  endfunction

  // Any captured shift bit strictly below the current stage index.
  always_comb begin
    low_bits_set = 1'b0;
    for (int unsigned i = 0; i < SHW; i++) begin
      if ((i < {{(32-KW){1'b0}}, k_q}) && shift_q[i]) begin
        low_bits_set = 1'b1;
      end
    end
  end

`ifdef SHR_EARLY_DONE_EN
  // Nothing left to apply below this stage, so this stage is the last one.
  assign last_stage = !low_bits_set;
`else
  assign last_stage = (k_q == '0);
`endif

  assign stage_val = shift_q[k_q] ? shift_stage(work_q, op_q, sign_q, k_q) : work_q;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    work_d  = work_q;
    shift_d = shift_q;
    sign_d  = sign_q;
    k_d     = k_q;
    out_d   = out_q;
    zero_d  = zero_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          work_d  = a;
          shift_d = shift;
          op_d    = decode_mode(mode);
          sign_d  = a[WIDTH-1];
          k_d     = K_FIRST;
          state_d = S_BUSY;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        work_d = stage_val;
        if (last_stage) begin
          out_d   = stage_val;
          zero_d  = (stage_val == '0);
          state_d = S_DONE;
        end else begin
          k_d = k_q - K_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= OP_SRL;
      work_q  <= '0;
      shift_q <= '0;
      sign_q  <= 1'b0;
      k_q     <= '0;
      out_q   <= '0;
      zero_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      work_q  <= work_d;
      shift_q <= shift_d;
      sign_q  <= sign_d;
      k_q     <= k_d;
      out_q   <= out_d;
      zero_q  <= zero_d;
    end
  end

  always_comb begin
    ready = (state_q == S_IDLE) || (state_q == S_DONE);
    busy  = (state_q == S_BUSY);
    done  = (state_q == S_DONE);
    out   = out_q;
    zero  = zero_q;
  end

endmodule

// File: tb/tb_seq_right_shifter.sv
// Scoreboard bench for seq_right_shifter: the driver pushes expected
// result/zero/latency on issue, and the monitor pops and compares on each
// done pulse.

module tb_seq_right_shifter;

  localparam int WIDTH = 16;
  localparam int SHW   = 4;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [SHW-1:0]   shift;
  logic [1:0]       mode;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out;
  logic             zero;

  seq_right_shifter #(.WIDTH(WIDTH), .SHW(SHW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .shift (shift),
    .mode  (mode),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .out   (out),
    .zero  (zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] res;
    logic        z;
    int          lat;
    int          acc;
  } exp_t;

  typedef struct {
    logic [1:0]  m;
    logic [15:0] a;
    logic [3:0]  s;
    logic [15:0] res;
  } vec_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   busy_cnt    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int exp_lat(input logic [3:0] s);
`ifdef SHR_EARLY_DONE_EN
    if (s == 4'd0) return 1;
    for (int i = 0; i < 4; i++) begin
      if (s[i]) return 4 - i;
    end
    return 4;
`else
    return 4;
`endif
  endfunction

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_done: got done=1 expected no pending operation (t=%0t)", $time);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("out", {16'h0, out}, {16'h0, e.res});
          chk("zero", {31'h0, zero}, {31'h0, e.z});
          chk("latency", cyc - e.acc, e.lat);
          chk("busy_cycles", busy_cnt, e.lat);
        end
        busy_cnt = 0;
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after the accept edge.
  task automatic run_op(input logic [1:0] m, input logic [15:0] av, input logic [3:0] s,
                        input logic [15:0] res, input bit expect_done);
    int n;
    exp_t e;
    n = 0;
    while (!ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      vectors++;
      miscompares++;
      $display("FAIL ready_timeout: got ready=0 expected ready=1 within 50 cycles");
      return;
    end
    a     = av;
    shift = s;
    mode  = m;
    start = 1'b1;
    if (expect_done) begin
      e.res = res;
      e.z   = (res == 16'h0);
      e.lat = exp_lat(s);
      e.acc = cyc + 1;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  vec_t vecs[14];

  initial begin
    vecs[0]  = '{2'b01, 16'h8000, 4'd4,  16'hF800};
    vecs[1]  = '{2'b10, 16'h1234, 4'd4,  16'h4123};
    vecs[2]  = '{2'b00, 16'h8000, 4'd15, 16'h0001};
    vecs[3]  = '{2'b01, 16'h8000, 4'd15, 16'hFFFF};
    vecs[4]  = '{2'b00, 16'h00F0, 4'd8,  16'h0000};
    vecs[5]  = '{2'b01, 16'h00F0, 4'd0,  16'h00F0};
    vecs[6]  = '{2'b11, 16'hF0F0, 4'd4,  16'h0F0F};
    vecs[7]  = '{2'b10, 16'h8001, 4'd15, 16'h0003};
    vecs[8]  = '{2'b01, 16'h4000, 4'd15, 16'h0000};
    vecs[9]  = '{2'b01, 16'hF000, 4'd2,  16'hFC00};
    vecs[10] = '{2'b10, 16'hBEEF, 4'd0,  16'hBEEF};
    vecs[11] = '{2'b00, 16'hFFFF, 4'd5,  16'h07FF};
    vecs[12] = '{2'b10, 16'h00F0, 4'd6,  16'hC003};
    vecs[13] = '{2'b11, 16'h8000, 4'd15, 16'h0001};

    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    shift = '0;
    mode  = '0;
    repeat (2) @(negedge clk);
    chk("rst_out",   {16'h0, out},   32'h0);
    chk("rst_zero",  {31'h0, zero},  32'h1);
    chk("rst_ready", {31'h0, ready}, 32'h1);
    chk("rst_busy",  {31'h0, busy},  32'h0);
    chk("rst_done",  {31'h0, done},  32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors; even entries leave an idle gap, odd ones go back-to-back.
    for (int i = 0; i < 14; i++) begin
      run_op(vecs[i].m, vecs[i].a, vecs[i].s, vecs[i].res, 1'b1);
      if (i % 2 == 1) repeat (7) @(negedge clk);
    end
    repeat (7) @(negedge clk);

    // Back-to-back via start held into DONE, then disturb inputs while BUSY.
    run_op(2'b10, 16'hABCD, 4'd8, 16'hCDAB, 1'b1);
    run_op(2'b01, 16'h7FFF, 4'd1, 16'h3FFF, 1'b1);
    a     = 16'hFFFF;
    mode  = 2'b10;
    shift = 4'd0;
    start = 1'b1;
    @(negedge clk);
    chk("out_hold_busy", {16'h0, out}, 32'h0000CDAB);
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);

    // Reset during the second BUSY cycle aborts with no done.
    run_op(2'b00, 16'h1234, 4'd3, 16'h0000, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_out",   {16'h0, out},   32'h0);
    chk("abort_zero",  {31'h0, zero},  32'h1);
    chk("abort_ready", {31'h0, ready}, 32'h1);
    chk("abort_busy",  {31'h0, busy},  32'h0);
    chk("abort_done",  {31'h0, done},  32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(2'b10, 16'h0001, 4'd1, 16'h8000, 1'b1);

    for (int n = 0; n < 100 && (sb.size() != 0 || !ready); n++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
